// File: rtl/dvp_pixel_packer.sv
// dvp_pixel_packer
//   Capture front-end for an OV5640-style 8-bit DVP bus. It registers the bus
//   once on the pixel clock, packs byte pairs into RGB565 words and tags each
//   word with its column/row, start-of-frame and end-of-line. VSYNC delimits
//   frames and HREF delimits lines. Words outside the resolution latched at
//   frame start are clipped. Words that arrive while the FIFO is full are
//   dropped and flagged.
//
// Ports
//   cam_pclk_i / resetn_i          pixel clock, async active-low reset
//   cam_half_pixel_i, cam_href,    DVP byte, line qualifier, vertical blanking
//   cam_vsync
//   resolution_width_i/_depth_i    pixels per line / lines per frame
//                                  (sampled at frame start)
//   fifo_full_i                    pixel FIFO full flag
//   pixel_o, pixel_valid_o         packed word and FIFO write enable
//   sof_o, eol_o, x_o, y_o         tags of the current word
//   frame_done_o                   one-cycle pulse when an active frame ends
//   frame_err_o                    sticky frame-size mismatch
//   overflow_o                     sticky dropped-word flag
//
// Build option
//   DVP_FRAME_CHECK_EN  enables the line-length, odd-byte and line-count
//                       checks behind frame_err_o. When it is undefined,
//                       frame_err_o is tied low.
module dvp_pixel_packer #(
  parameter int DATA_WIDTH  = 8,
  parameter int PIXEL_WIDTH = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   cam_pclk_i,
  input  logic                   resetn_i,
  input  logic [DATA_WIDTH-1:0]  cam_half_pixel_i,
  input  logic                   cam_href,
  input  logic                   cam_vsync,
  input  logic [CNT_WIDTH-1:0]   resolution_width_i,
  input  logic [CNT_WIDTH-1:0]   resolution_depth_i,
  input  logic                   fifo_full_i,
  output logic [PIXEL_WIDTH-1:0] pixel_o,
  output logic                   pixel_valid_o,
  output logic                   sof_o,
  output logic                   eol_o,
  output logic [CNT_WIDTH-1:0]   x_o,
  output logic [CNT_WIDTH-1:0]   y_o,
  output logic                   frame_done_o,
  output logic                   frame_err_o,
  output logic                   overflow_o
);

  typedef enum logic [1:0] {S_SYNC, S_VBLANK, S_FRAME} state_t;

  state_t r_state, w_state_nxt;

  logic [DATA_WIDTH-1:0] r_data_d, r_hi;
  logic                  r_href_d, r_vsync_d;
  logic                  r_phase, r_href_prev, r_first;
  logic [CNT_WIDTH-1:0]  r_x, r_y, r_w_lat, r_d_lat;

  logic                  w_start, w_end, w_in_frame, w_word, w_line_end;
  logic                  w_clip, w_write;
  logic [CNT_WIDTH-1:0]  w_x_inc, w_y_inc;

  // Input stage: the _d copies feed all downstream logic. Data is not reset;
  // it is only consumed while qualified by the reset control path.
  always_ff @(posedge cam_pclk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_href_d  <= 1'b0;
      r_vsync_d <= 1'b0;
    end else begin
      r_href_d  <= cam_href;
      r_vsync_d <= cam_vsync;
    end
  end

  always_ff @(posedge cam_pclk_i) begin
    r_data_d <= cam_half_pixel_i;
    if (w_in_frame && r_href_d && !r_phase) r_hi <= r_data_d;
    if (w_start) begin
      r_w_lat <= resolution_width_i;
      r_d_lat <= resolution_depth_i;
    end
  end

  // Frame FSM
  always_ff @(posedge cam_pclk_i or negedge resetn_i) begin
    if (!resetn_i) r_state <= S_SYNC;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      S_SYNC:   if (r_vsync_d) w_state_nxt = S_VBLANK;
      S_VBLANK: if (!r_vsync_d) begin
                  w_state_nxt = S_FRAME;
                  w_start     = 1'b1;
                end
      S_FRAME:  if (r_vsync_d) begin
                  w_state_nxt = S_VBLANK;
                  w_end       = 1'b1;
                end
      default:  w_state_nxt = S_SYNC;
    endcase
  end

  assign w_in_frame = (r_state == S_FRAME);
  assign w_word     = w_in_frame && r_href_d && r_phase;
  // r_href_prev is only set for bytes seen inside the frame, so a line end
  // always follows at least one counted byte.
  assign w_line_end = w_in_frame && r_href_prev && !r_href_d;
  assign w_clip     = (r_x >= r_w_lat) || (r_y >= r_d_lat);
  assign w_write    = w_word && !w_clip && !fifo_full_i;
  assign w_x_inc    = (r_x == '1) ? r_x : r_x + CNT_WIDTH'(1);
  assign w_y_inc    = (r_y == '1) ? r_y : r_y + CNT_WIDTH'(1);

  // Output stage: packing, counters and tags
  always_ff @(posedge cam_pclk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_phase       <= 1'b0;
      r_href_prev   <= 1'b0;
      r_first       <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      pixel_o       <= '0;
      pixel_valid_o <= 1'b0;
      sof_o         <= 1'b0;
      eol_o         <= 1'b0;
      x_o           <= '0;
      y_o           <= '0;
      frame_done_o  <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      pixel_valid_o <= 1'b0;
      sof_o         <= 1'b0;
      eol_o         <= 1'b0;
      frame_done_o  <= w_end;
      // A dangling odd byte leaves r_phase=1 and is discarded when href drops.
      r_phase       <= (w_in_frame && r_href_d) ? !r_phase : 1'b0;
      r_href_prev   <= w_in_frame && r_href_d;
      if (w_start) begin
        r_x        <= '0;
        r_y        <= '0;
        r_first    <= 1'b1;
        overflow_o <= 1'b0;
      end else begin
        if (w_word) begin
          // Clipped and dropped words still advance x so later columns stay aligned.
          r_x <= w_x_inc;
          if (!w_clip && fifo_full_i) overflow_o <= 1'b1;
          if (w_write) begin
            pixel_valid_o <= 1'b1;
            pixel_o       <= {r_hi, r_data_d};
            x_o           <= r_x;
            y_o           <= r_y;
            sof_o         <= r_first;
            eol_o         <= (r_x == r_w_lat - CNT_WIDTH'(1));
            r_first       <= 1'b0;
          end
        end
        if (w_line_end) begin
          r_x <= '0;
          r_y <= w_y_inc;
        end
      end
    end
  end

`ifdef DVP_FRAME_CHECK_EN
  logic [CNT_WIDTH-1:0] w_y_final;

  // A line end that coincides with the frame end has not updated r_y yet.
  assign w_y_final = w_line_end ? w_y_inc : r_y;

  always_ff @(posedge cam_pclk_i or negedge resetn_i) begin
    if (!resetn_i)
      frame_err_o <= 1'b0;
    else if (w_start)
      frame_err_o <= 1'b0;
    else if ((w_line_end && ((r_x != r_w_lat) || r_phase)) ||
             (w_end && (w_y_final != r_d_lat)))
      frame_err_o <= 1'b1;
  end
`else
  assign frame_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dvp_pixel_packer.sv
module tb_dvp_pixel_packer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  data;
  logic        href, vsync, full;
  logic [15:0] res_w, res_d;

  logic [15:0] pixel_o, x_o, y_o;
  logic        pixel_valid_o, sof_o, eol_o, frame_done_o, frame_err_o, overflow_o;

`ifdef DVP_FRAME_CHECK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  dvp_pixel_packer #(.DATA_WIDTH(8), .PIXEL_WIDTH(16), .CNT_WIDTH(16)) dut (
    .cam_pclk_i        (clk),
    .resetn_i          (rstn),
    .cam_half_pixel_i  (data),
    .cam_href          (href),
    .cam_vsync         (vsync),
    .resolution_width_i(res_w),
    .resolution_depth_i(res_d),
    .fifo_full_i       (full),
    .pixel_o           (pixel_o),
    .pixel_valid_o     (pixel_valid_o),
    .sof_o             (sof_o),
    .eol_o             (eol_o),
    .x_o               (x_o),
    .y_o               (y_o),
    .frame_done_o      (frame_done_o),
    .frame_err_o       (frame_err_o),
    .overflow_o        (overflow_o)
  );

  int checks = 0;
  int errors = 0;

  // Capture of every written word, sampled on the falling edge.
  logic [15:0] mon_pix [0:1023];
  logic [15:0] mon_x   [0:1023];
  logic [15:0] mon_y   [0:1023];
  logic        mon_sof [0:1023];
  logic        mon_eol [0:1023];
  int          mon_n = 0;
  int          done_n = 0;
  logic        err_at_done = 1'b0;

  always @(negedge clk) begin
    if (pixel_valid_o && mon_n < 1024) begin
      mon_pix[mon_n] = pixel_o;
      mon_x[mon_n]   = x_o;
      mon_y[mon_n]   = y_o;
      mon_sof[mon_n] = sof_o;
      mon_eol[mon_n] = eol_o;
      mon_n++;
    end
    if (frame_done_o) begin
      done_n++;
      err_at_done = frame_err_o;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      href = 1'b0;
      full = 1'b0;
    end
  endtask

  task automatic start_frame();
    repeat (4) begin
      @(negedge clk);
      vsync = 1'b1;
      href  = 1'b0;
    end
    @(negedge clk);
    vsync = 1'b0;
    idle(4);
  endtask

  task automatic end_frame();
    idle(3);
    repeat (6) begin
      @(negedge clk);
      vsync = 1'b1;
      href  = 1'b0;
    end
  endtask

  // Bytes are (start + step*i) mod 256; fifo_full is high while f_lo <= i <= f_hi.
  task automatic send_line(input int n, input int start, input int step,
                           input int f_lo, input int f_hi);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      href = 1'b1;
      data = 8'((start + step * i) & 255);
      full = (i >= f_lo) && (i <= f_hi);
    end
    idle(4);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle(3);
    checks++;
    if ({pixel_valid_o, sof_o, eol_o, frame_done_o, frame_err_o, overflow_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {pixel_valid_o, sof_o, eol_o, frame_done_o, frame_err_o, overflow_o});
    end
    checks++;
    if ({pixel_o, x_o, y_o} !== 48'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {pixel_o, x_o, y_o});
    end
    @(negedge clk);
    rstn = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    int base, dn;
    base = mon_n;
    dn = done_n;
    res_w = 16'd4;
    res_d = 16'd2;
    start_frame();
    send_line(8, 'h12, 'h22, -1, -1);
    send_line(8, 'h122, 'h22, -1, -1);
    end_frame();
    checks++;
    if (mon_n - base !== 8) begin
      errors++;
      $display("FAIL basic_count: got %0d expected 8", mon_n - base);
    end
    checks++;
    if ({mon_pix[base], mon_sof[base], mon_x[base], mon_y[base]} !== {16'h1234, 1'b1, 16'd0, 16'd0}) begin
      errors++;
      $display("FAIL basic_first: got pix=%h sof=%b x=%0d y=%0d expected 1234 1 0 0",
               mon_pix[base], mon_sof[base], mon_x[base], mon_y[base]);
    end
    checks++;
    if (mon_sof[base+1] !== 1'b0) begin
      errors++;
      $display("FAIL basic_sof_once: got %b expected 0", mon_sof[base+1]);
    end
    checks++;
    if ({mon_pix[base+3], mon_eol[base+3], mon_x[base+3]} !== {16'hDE00, 1'b1, 16'd3}) begin
      errors++;
      $display("FAIL basic_eol: got pix=%h eol=%b x=%0d expected DE00 1 3",
               mon_pix[base+3], mon_eol[base+3], mon_x[base+3]);
    end
    checks++;
    if (mon_eol[base+2] !== 1'b0) begin
      errors++;
      $display("FAIL basic_no_eol: got %b expected 0", mon_eol[base+2]);
    end
    checks++;
    if ({mon_pix[base+4], mon_x[base+4], mon_y[base+4]} !== {16'h2244, 16'd0, 16'd1}) begin
      errors++;
      $display("FAIL basic_line2: got pix=%h x=%0d y=%0d expected 2244 0 1",
               mon_pix[base+4], mon_x[base+4], mon_y[base+4]);
    end
    checks++;
    if ({mon_pix[base+7], mon_x[base+7], mon_y[base+7]} !== {16'hEE10, 16'd3, 16'd1}) begin
      errors++;
      $display("FAIL basic_last: got pix=%h x=%0d y=%0d expected EE10 3 1",
               mon_pix[base+7], mon_x[base+7], mon_y[base+7]);
    end
    checks++;
    if (done_n - dn !== 1) begin
      errors++;
      $display("FAIL basic_done_pulse: got %0d cycles expected 1", done_n - dn);
    end
    checks++;
    if (err_at_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_frame_err: got %b expected 0", err_at_done);
    end
  endtask

  task automatic test_ramp();
    int base;
    logic [7:0]  b0, b1;
    logic [15:0] exp_pix;
    base = mon_n;
    res_w = 16'd8;
    res_d = 16'd4;
    start_frame();
    for (int j = 0; j < 4; j++) send_line(16, j, 1, -1, -1);
    end_frame();
    checks++;
    if (mon_n - base !== 32) begin
      errors++;
      $display("FAIL ramp_count: got %0d expected 32", mon_n - base);
    end
    for (int k = 0; k < 32; k++) begin
      b0 = 8'((k / 8 + 2 * (k % 8)) & 255);
      b1 = 8'((k / 8 + 2 * (k % 8) + 1) & 255);
      exp_pix = {b0, b1};
      checks++;
      if ({mon_pix[base+k], mon_x[base+k], mon_y[base+k], mon_eol[base+k]} !==
          {exp_pix, 16'(k % 8), 16'(k / 8), (k % 8) == 7}) begin
        errors++;
        $display("FAIL ramp_word%0d: got pix=%h x=%0d y=%0d eol=%b expected %h %0d %0d %b",
                 k, mon_pix[base+k], mon_x[base+k], mon_y[base+k], mon_eol[base+k],
                 exp_pix, k % 8, k / 8, (k % 8) == 7);
      end
    end
    checks++;
    if (err_at_done !== 1'b0) begin
      errors++;
      $display("FAIL ramp_frame_err: got %b expected 0", err_at_done);
    end
  endtask

  task automatic test_overwide();
    int base;
    base = mon_n;
    res_w = 16'd4;
    res_d = 16'd1;
    start_frame();
    send_line(12, 'h40, 1, -1, -1);
    end_frame();
    checks++;
    if (mon_n - base !== 4) begin
      errors++;
      $display("FAIL overwide_count: got %0d expected 4", mon_n - base);
    end
    checks++;
    if ({mon_pix[base+3], mon_x[base+3], mon_eol[base+3]} !== {16'h4647, 16'd3, 1'b1}) begin
      errors++;
      $display("FAIL overwide_last: got pix=%h x=%0d eol=%b expected 4647 3 1",
               mon_pix[base+3], mon_x[base+3], mon_eol[base+3]);
    end
    checks++;
    if (err_at_done !== CHK_EN) begin
      errors++;
      $display("FAIL overwide_frame_err: got %b expected %b", err_at_done, CHK_EN);
    end
  endtask

  task automatic test_odd_bytes();
    int base;
    base = mon_n;
    res_w = 16'd3;
    res_d = 16'd1;
    start_frame();
    send_line(7, 'h01, 1, -1, -1);
    end_frame();
    checks++;
    if (mon_n - base !== 3) begin
      errors++;
      $display("FAIL odd_count: got %0d expected 3", mon_n - base);
    end
    checks++;
    if ({mon_pix[base+2], mon_x[base+2], mon_eol[base+2]} !== {16'h0506, 16'd2, 1'b1}) begin
      errors++;
      $display("FAIL odd_last: got pix=%h x=%0d eol=%b expected 0506 2 1",
               mon_pix[base+2], mon_x[base+2], mon_eol[base+2]);
    end
    checks++;
    if (err_at_done !== CHK_EN) begin
      errors++;
      $display("FAIL odd_frame_err: got %b expected %b", err_at_done, CHK_EN);
    end
  endtask

  task automatic test_fifo_full();
    int base;
    logic [15:0] exp_x   [0:4];
    logic [15:0] exp_pix [0:4];
    exp_x   = '{16'd0, 16'd1, 16'd5, 16'd6, 16'd7};
    exp_pix = '{16'h1011, 16'h1213, 16'h1A1B, 16'h1C1D, 16'h1E1F};
    base = mon_n;
    res_w = 16'd8;
    res_d = 16'd1;
    start_frame();
    // Full is sampled with the word whose second byte came one cycle earlier:
    // holding it for bytes 6..11 blocks the words at x=2,3,4.
    send_line(16, 'h10, 1, 6, 11);
    end_frame();
    checks++;
    if (mon_n - base !== 5) begin
      errors++;
      $display("FAIL full_count: got %0d expected 5", mon_n - base);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({mon_pix[base+k], mon_x[base+k]} !== {exp_pix[k], exp_x[k]}) begin
        errors++;
        $display("FAIL full_word%0d: got pix=%h x=%0d expected %h %0d",
                 k, mon_pix[base+k], mon_x[base+k], exp_pix[k], exp_x[k]);
      end
    end
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL full_overflow_set: got %b expected 1", overflow_o);
    end
    checks++;
    if (err_at_done !== 1'b0) begin
      errors++;
      $display("FAIL full_frame_err: got %b expected 0", err_at_done);
    end
    start_frame();
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL full_overflow_clear: got %b expected 0", overflow_o);
    end
  endtask

  task automatic test_reset_midline();
    int base;
    res_w = 16'd4;
    res_d = 16'd1;
    start_frame();
    send_line(8, 'h50, 1, -1, -1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      href = 1'b1;
      data = 8'(8'h60 + i);
    end
    @(negedge clk);
    rstn = 1'b0;
    data = 8'h63;
    #1;
    checks++;
    if ({pixel_valid_o, sof_o, eol_o, frame_done_o, frame_err_o, overflow_o, pixel_o, x_o, y_o} !== 54'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h expected 0",
               {pixel_valid_o, sof_o, eol_o, frame_done_o, frame_err_o, overflow_o, pixel_o, x_o, y_o});
    end
    repeat (3) begin
      @(negedge clk);
      data = data + 8'd1;
    end
    @(negedge clk);
    rstn = 1'b1;
    base = mon_n;
    send_line(8, 'h20, 1, -1, -1);
    checks++;
    if (mon_n - base !== 0) begin
      errors++;
      $display("FAIL midreset_no_write: got %0d writes expected 0", mon_n - base);
    end
    base = mon_n;
    start_frame();
    send_line(8, 'h30, 1, -1, -1);
    end_frame();
    checks++;
    if (mon_n - base !== 4) begin
      errors++;
      $display("FAIL midreset_count: got %0d expected 4", mon_n - base);
    end
    checks++;
    if ({mon_pix[base], mon_sof[base], mon_x[base]} !== {16'h3031, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL midreset_first: got pix=%h sof=%b x=%0d expected 3031 1 0",
               mon_pix[base], mon_sof[base], mon_x[base]);
    end
  endtask

  initial begin
    rstn  = 1'b0;
    data  = 8'h00;
    href  = 1'b0;
    vsync = 1'b0;
    full  = 1'b0;
    res_w = 16'd4;
    res_d = 16'd2;
    test_reset();
    test_basic();
    test_ramp();
    test_overwide();
    test_odd_bytes();
    test_fifo_full();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvp_pixel_packer.md
# dvp_pixel_packer

Camera-side capture front-end of the DVP receive path: samples the OV5640 8-bit DVP bus on the pixel clock and packs byte pairs into 16-bit RGB565 words. It delimits frames with VSYNC and lines with HREF, and tags each word with column, row, start-of-frame and end-of-line. Words are written into the async pixel FIFO (16-bit, 2^11 deep) that feeds the frame buffer and HDMI output. The packer enforces the configured resolution and reports overflow and frame-size errors.

## Interface
- DATA_WIDTH, 8: DVP byte width.
- PIXEL_WIDTH, 16: packed word width; must equal 2*DATA_WIDTH.
- CNT_WIDTH, 16: width of the column/row counters and of the resolution inputs.

- cam_pclk_i  in  1  camera pixel clock; sole clock of the block.
- resetn_i  in  1  asynchronous active-low reset.
- cam_half_pixel_i  in  DATA_WIDTH  DVP data byte.
- cam_href  in  1  line-active qualifier, high during active bytes.
- cam_vsync  in  1  high during vertical blanking, low during the frame.
- resolution_width_i  in  CNT_WIDTH  pixels per line (640 nominal); sampled at frame start.
- resolution_depth_i  in  CNT_WIDTH  lines per frame (480 nominal); sampled at frame start.
- fifo_full_i  in  1  pixel FIFO full flag, write-clock domain.
- pixel_o  out  PIXEL_WIDTH  packed RGB565 word.
- pixel_valid_o  out  1  FIFO write enable; one word per pulse.
- sof_o  out  1  qualifies the first written word of a frame (x=0, y=0).
- eol_o  out  1  qualifies the word with x = width-1.
- x_o, y_o  out  CNT_WIDTH each  coordinate of the current pixel_o.
- frame_done_o  out  1  one-cycle pulse on the VSYNC rising edge that ends an active frame.
- frame_err_o  out  1  sticky size-mismatch flag.
- overflow_o  out  1  sticky flag, set when a word is dropped because the FIFO is full.

## Operation
- Input stage: cam_half_pixel_i, cam_href and cam_vsync are registered once (the _d copies). All of the logic below uses the _d copies only.
- The FSM has three states:
  - S_SYNC, the reset state: moves to S_VBLANK when vsync_d=1. A frame already in progress at reset release is discarded.
  - S_VBLANK: moves to S_FRAME when vsync_d=0. On this transition the block latches both resolution inputs, clears x, y, frame_err_o and overflow_o, and sets a first-word flag.
  - S_FRAME: moves to S_VBLANK when vsync_d=1, pulsing frame_done_o on the same edge.
- Byte phase:
  - The phase toggles on every cycle with href_d=1 and is forced to 0 whenever href_d=0.
  - Phase 0 stores the byte as the high byte; phase 1 completes the word {high, current}.
- Word handling on a complete word:
  - Clipped if x ≥ width_lat or y ≥ depth_lat: the word is not written and x still increments (saturating at all-ones).
  - Dropped if fifo_full_i=1: the word is not written, overflow_o is set, and x still increments.
  - Otherwise pixel_valid_o=1 with pixel_o, x_o and y_o.
- Line end is the href_d 1→0 transition in S_FRAME after at least one byte:
  - y increments (saturating) and x clears.
  - An odd trailing byte is discarded.
- href_d activity in S_VBLANK or S_SYNC is ignored.
- All arithmetic is unsigned CNT_WIDTH. Counter comparisons are made against the latched resolution, not the live inputs.

## Timing
- Latency: the byte presented with the second byte of a pair is registered at posedge N; pixel_valid_o is high after posedge N+1. The pipeline is two pclk deep.
- Throughput: at most one word every 2 pclk.
- Every output is a register; no combinational path runs from input to output.
- Reset values: all outputs 0, state S_SYNC, phase 0.
- frame_done_o is high for exactly one cycle, in the cycle after vsync_d rises. frame_err_o is final in that same cycle.
- When a word completes in the same cycle that href_d falls, the word is processed first and the line-end update follows on the next edge.
- Reset mid-frame: outputs clear immediately (asynchronously). No partial word is emitted after reset release.

## Configuration
- DVP_FRAME_CHECK_EN defined:
  - frame_err_o is set when a line ends with x ≠ width_lat.
  - It is also set on an odd byte count in a line.
  - It is also set when a frame ends with y ≠ depth_lat.
- Not defined: frame_err_o is tied to 0 and the check logic is absent. Clipping, overflow detection and all other behaviour are unchanged.

## Test plan
- Basic packing, width=4, depth=2: two lines of bytes 0x12,0x34,0x56,0x78,… -> 8 writes; the first is 0x1234 with sof_o=1 at x=0,y=0; eol_o at x=3; frame_done_o pulse; frame_err_o=0.
- Full frame 640x480 (20-pclk porches, ramp data (i+j)%256) -> exactly 307200 writes; the last word is at x=639,y=479; every word equals {byte2k, byte2k+1}.
- Over-wide line, width=4, 6 pixels sent -> 4 writes for that line; with the macro, frame_err_o=1 at frame_done_o.
- Odd byte count, 7 bytes in a line -> 3 writes; the trailing byte is dropped; frame_err_o=1 with the macro, 0 without.
- FIFO full held for 3 word slots mid-line -> those 3 words are absent, overflow_o=1; following words keep correct x values; overflow_o clears at the next VSYNC fall.
- Reset asserted mid-line, then released with vsync=0 -> no writes until a full VSYNC high→low cycle occurs; all outputs are 0 during reset.
